transform_primary_inverse: RTL and testbench
============================================

Name: transform_primary_inverse

Overview:
Inverse of the radix-2 primary butterfly stage. It consumes pairs of (WIDTH+1)-bit complex sum/difference samples y0 = x0+x1 and y1 = x0-x1. It reconstructs the original WIDTH-bit pair x0 = (y0+y1)/2 and x1 = (y0-y1)/2, emitted in order x0 then x1. It sits on the receive/inverse path opposite the forward primary stage and uses the same valid/ready streaming handshake on both sides.

Parameters:
WIDTH, 16, component width of reconstructed output samples; input components are WIDTH+1 bits.

Ports:
clk  input  1  clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
s_valid  input  1  input sample valid.
s_ready  output  1  input sample ready; transfer when s_valid & s_ready.
s_data  input  2*WIDTH+2  {imag[WIDTH:0], real[WIDTH:0]}, signed two's complement.
m_valid  output  1  output sample valid.
m_ready  input  1  downstream ready; transfer when m_valid & m_ready.
m_data  output  2*WIDTH  {imag[WIDTH-1:0], real[WIDTH-1:0]}, signed.
m_last  output  1  high with x1 (second sample of a pair), low with x0.
err  output  1  one-cycle pulse: pair had odd sum/difference parity or required saturation.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: m_valid=0, m_last=0, err=0, state=FIRST. m_data is don't-care but must be deterministic.
- FSM states: FIRST, SECOND, EMIT0, EMIT1.
  - FIRST: s_ready=1. On input transfer, register y0 and go to SECOND.
  - SECOND: s_ready=1. On transfer, compute x0/x1 from held y0 and incoming y1, register both, go to EMIT0.
  - EMIT0: m_valid=1, m_data=x0, m_last=0, s_ready=0. On m_ready go to EMIT1; otherwise hold.
  - EMIT1: m_valid=1, m_data=x1, m_last=1, s_ready=m_ready (combinational).
    - m_ready=1 with an input transfer: register new y0, go to SECOND.
    - m_ready=1 without an input transfer: go to FIRST.
    - m_ready=0: hold; no input is accepted.
- Latency: m_valid rises the cycle after the second input transfer.
- Throughput: steady state is 3 cycles per pair, with s_valid and m_ready held high.
- Output data, m_last and state hold stable while m_valid & !m_ready. No sample is lost or duplicated under any back-pressure pattern.
- Arithmetic, per component (real and imag independently):
  - sum = y0+y1 and diff = y0-y1, sign-extended to WIDTH+2 bits.
  - Arithmetic shift right by 1 (floor).
  - Saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- err rises in the same cycle m_valid rises for x0, and lasts exactly 1 cycle. It is set if any of the 4 components has an odd sum/diff LSB or saturated. Valid forward-stage outputs never set err.
- Input s_valid with s_ready low is ignored; there is no overflow path.
- Reset mid-operation: a held y0 and pending x0/x1 are discarded. The first input transfer after reset is treated as y0.

Decomposition:
- Shared package transform_pkg holds:
  - the state enum (FIRST, SECOND, EMIT0, EMIT1);
  - localparam-free helper functions sign_extend and saturate, written for generic widths via let/parameterized class static functions.
- Sub-module transform_halve (combinational):
  - inputs: a, b (WIDTH+1), op (add/sub);
  - outputs: q (WIDTH), odd, sat;
  - instantiated 4 times (real/imag × sum/diff).
- Top level contains only the FSM, pair registers and handshake.

Test Plan:
- WIDTH=16, y0=(4,-3), y1=(2,-7) with m_ready=1 → x0=(3,-5) (m_last=0), then x1=(1,2) (m_last=1). m_valid rises 1 cycle after the second transfer; err=0.
- y0=(65534,-65536), y1=(0,0) → x0=(32767,-32768), x1=(32767,-32768), err=0.
- y0=(1,0), y1=(0,0) → x0=(0,0), x1=(0,0) by floor, err pulses 1 cycle.
- y0=(65535,0), y1=(65535,0) → x0=(32767,0) saturated, x1=(0,0), err pulses.
- Back-pressure: m_ready=0 for 5 cycles in EMIT0 → m_data/m_last stable, s_ready=0. Then a continuous 8-pair stream with m_ready=1 → one pair per 3 cycles, outputs in order, none dropped.
- Reset asserted for 1 cycle after the first input transfer → held y0 discarded, no output. The next two transfers, y0=(4,-3) and y1=(2,-7), produce (3,-5) then (1,2).

Source files
------------

// File: rtl/transform_pkg.sv
// Shared definitions for the inverse primary butterfly stage.
//   state_t     : control states of the pair-reconstruction FSM
//   op_t        : add/subtract selector for the halving datapath
//   sign_extend : widen a w-bit two's complement value to 64 bits
//   saturate    : clip a 64-bit signed value into the signed w-bit range
package transform_pkg;

  typedef enum logic [1:0] {
    FIRST  = 2'd0,
    SECOND = 2'd1,
    EMIT0  = 2'd2,
    EMIT1  = 2'd3
  } state_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  // Widths up to 63 bits are supported; the low w bits of v hold the value.
  function automatic logic signed [63:0] sign_extend(input logic [63:0] v, input int w);
    logic signed [63:0] t;
    t = $signed(v << (64 - w));
    return t >>> (64 - w);
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/transform_primary_inverse_if.sv
// Streaming bus of the inverse primary stage.
//   s_valid/s_ready/s_data : input pair samples {imag[WIDTH:0], real[WIDTH:0]}
//   m_valid/m_ready/m_data : reconstructed samples {imag[WIDTH-1:0], real[WIDTH-1:0]}
//   m_last                 : marks x1, the second sample of a pair
//   err                    : one-cycle parity/saturation flag aligned with x0
// slave is the design's view, master is the view of whoever drives it.
interface transform_primary_inverse_if #(
  parameter int WIDTH = 16
);
  logic                 s_valid;
  logic                 s_ready;
  logic [2*WIDTH+1:0]   s_data;
  logic                 m_valid;
  logic                 m_ready;
  logic [2*WIDTH-1:0]   m_data;
  logic                 m_last;
  logic                 err;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last, err
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last, err
  );
endinterface

// File: rtl/transform_halve.sv
// Combinational halving unit: q = sat((a op b) >>> 1).
//   a, b : signed WIDTH+1 bit operands
//   op   : OP_ADD or OP_SUB
//   q    : signed WIDTH bit result, floor-halved and saturated
//   odd  : the full-precision sum/difference was odd (a bit was dropped)
//   sat  : the halved value did not fit in WIDTH bits
module transform_halve
  import transform_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH:0]   b,
  input  op_t              op,
  output logic [WIDTH-1:0] q,
  output logic             odd,
  output logic             sat
);

  logic signed [63:0] a_ext;
  logic signed [63:0] b_ext;
  logic signed [63:0] full;
  logic signed [63:0] half;
  logic signed [63:0] clip;

  always_comb begin
    a_ext = sign_extend(64'(a), WIDTH + 1);
    b_ext = sign_extend(64'(b), WIDTH + 1);
    full  = (op == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
    odd   = full[0];
    // Arithmetic shift gives floor division for negative values too.
    half  = full >>> 1;
    clip  = saturate(half, WIDTH);
    sat   = (clip != half);
    q     = clip[WIDTH-1:0];
  end

endmodule

// File: rtl/transform_primary_inverse.sv
// Inverse radix-2 primary butterfly: takes y0 = x0+x1 then y1 = x0-x1 and
// emits x0 = (y0+y1)/2 followed by x1 = (y0-y1)/2.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : streaming bus (slave view), see transform_primary_inverse_if
module transform_primary_inverse
  import transform_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                        clk,
  input logic                        reset,
  transform_primary_inverse_if.slave bus
);

  localparam int IW = WIDTH + 1;

  state_t               state_reg, state_next;
  logic [2*IW-1:0]      y0_reg, y0_next;
  logic [2*WIDTH-1:0]   x0_reg, x0_next;
  logic [2*WIDTH-1:0]   x1_reg, x1_next;
  logic                 err_reg, err_next;
  logic                 accept;

  logic [WIDTH-1:0]     q [4];
  logic [3:0]           odd;
  logic [3:0]           sat;

  // Lane gi: component gi%2 (0 real, 1 imag); gi<2 sum (x0), gi>=2 diff (x1).
  // Operand b comes straight from the bus so x0/x1 are ready on y1's transfer.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_halve
      localparam int C = gi % 2;
      transform_halve #(
        .WIDTH (WIDTH)
      ) u_halve (
        .a   (y0_reg[C*IW +: IW]),
        .b   (bus.s_data[C*IW +: IW]),
        .op  ((gi >= 2) ? OP_SUB : OP_ADD),
        .q   (q[gi]),
        .odd (odd[gi]),
        .sat (sat[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    y0_next    = y0_reg;
    x0_next    = x0_reg;
    x1_next    = x1_reg;
    err_next   = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      FIRST: begin
        accept = 1'b1;
        if (bus.s_valid) begin
          y0_next    = bus.s_data;
          state_next = SECOND;
        end
      end
      SECOND: begin
        accept = 1'b1;
        if (bus.s_valid) begin
          x0_next    = {q[1], q[0]};
          x1_next    = {q[3], q[2]};
          // err is registered here so it appears with the first cycle of x0 only.
          err_next   = |(odd | sat);
          state_next = EMIT0;
        end
      end
      EMIT0: begin
        if (bus.m_ready) state_next = EMIT1;
      end
      EMIT1: begin
        // Overlap the next pair's y0 with the x1 handoff to reach 3 cycles/pair.
        accept = bus.m_ready;
        if (bus.m_ready) begin
          if (bus.s_valid) begin
            y0_next    = bus.s_data;
            state_next = SECOND;
          end else begin
            state_next = FIRST;
          end
        end
      end
      default: state_next = FIRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= FIRST;
      y0_reg    <= '0;
      x0_reg    <= '0;
      x1_reg    <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      y0_reg    <= y0_next;
      x0_reg    <= x0_next;
      x1_reg    <= x1_next;
      err_reg   <= err_next;
    end
  end

  assign bus.s_ready = accept;
  assign bus.m_valid = (state_reg == EMIT0) || (state_reg == EMIT1);
  assign bus.m_last  = (state_reg == EMIT1);
  assign bus.m_data  = (state_reg == EMIT1) ? x1_reg : x0_reg;
  assign bus.err     = err_reg;

endmodule

// File: tb/tb_transform_primary_inverse.sv
module tb_transform_primary_inverse;
  localparam int WIDTH = 16;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   cycle;

  transform_primary_inverse_if #(.WIDTH(WIDTH)) bus ();

  transform_primary_inverse #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string nm;
    int y0re, y0im, y1re, y1im;
    int x0re, x0im, x1re, x1im;
    bit err;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [2*WIDTH+1:0] pk_y(input int re, input int im);
    return {17'(im), 17'(re)};
  endfunction

  function automatic logic [2*WIDTH-1:0] pk_x(input int re, input int im);
    return {16'(im), 16'(re)};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // One pair with m_ready held high; inputs driven and outputs sampled on negedges.
  task automatic run_pair(input vec_t v);
    @(negedge clk);
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = pk_y(v.y0re, v.y0im);
    check({v.nm, ".s_ready_y0"}, 64'(bus.s_ready), 64'd1);
    @(negedge clk);
    check({v.nm, ".s_ready_y1"}, 64'(bus.s_ready), 64'd1);
    check({v.nm, ".m_valid_early"}, 64'(bus.m_valid), 64'd0);
    bus.s_data = pk_y(v.y1re, v.y1im);
    @(negedge clk);
    bus.s_valid = 1'b0;
    check({v.nm, ".m_valid_x0"}, 64'(bus.m_valid), 64'd1);
    check({v.nm, ".m_last_x0"}, 64'(bus.m_last), 64'd0);
    check({v.nm, ".x0"}, 64'(bus.m_data), 64'(pk_x(v.x0re, v.x0im)));
    check({v.nm, ".err"}, 64'(bus.err), 64'(v.err));
    @(negedge clk);
    check({v.nm, ".m_valid_x1"}, 64'(bus.m_valid), 64'd1);
    check({v.nm, ".m_last_x1"}, 64'(bus.m_last), 64'd1);
    check({v.nm, ".x1"}, 64'(bus.m_data), 64'(pk_x(v.x1re, v.x1im)));
    check({v.nm, ".err_clear"}, 64'(bus.err), 64'd0);
    $display("pair %s: y0=(%0d,%0d) y1=(%0d,%0d) -> x0=(%0d,%0d) x1=(%0d,%0d) err=%0d",
             v.nm, v.y0re, v.y0im, v.y1re, v.y1im, v.x0re, v.x0im, v.x1re, v.x1im, v.err);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cycle  = 0;
    reset  = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;

    vecs[0] = '{"basic",   4, -3, 2, -7,          3, -5, 1, 2,          1'b0};
    vecs[1] = '{"edge",    65534, -65536, 0, 0,   32767, -32768, 32767, -32768, 1'b0};
    vecs[2] = '{"odd",     1, 0, 0, 0,            0, 0, 0, 0,           1'b1};
    vecs[3] = '{"satpos",  65535, 0, 65535, 0,    32767, 0, 0, 0,       1'b1};
    vecs[4] = '{"mixed",   -5, 7, 3, -1,          -1, 3, -4, 4,         1'b0};
    vecs[5] = '{"oddneg",  -3, 0, 0, 0,           -2, 0, -2, 0,         1'b1};
    vecs[6] = '{"satneg",  -65536, 0, -65536, 0,  -32768, 0, 0, 0,      1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset.m_valid", 64'(bus.m_valid), 64'd0);
    check("reset.m_last", 64'(bus.m_last), 64'd0);
    check("reset.err", 64'(bus.err), 64'd0);
    check("reset.s_ready", 64'(bus.s_ready), 64'd1);

    for (int i = 0; i < 7; i++) run_pair(vecs[i]);

    // Back-pressure: stall 5 cycles in EMIT0 while junk is offered on the input.
    // y0=(5,2) y1=(0,-1): sums (5,1) odd -> x0=(2,0); diffs (5,3) -> x1=(2,1); err.
    @(negedge clk);
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = pk_y(5, 2);
    @(negedge clk);
    bus.s_data  = pk_y(0, -1);
    @(negedge clk);
    bus.s_data  = pk_y(99, 99);
    for (int i = 0; i < 5; i++) begin
      check("bp.m_valid", 64'(bus.m_valid), 64'd1);
      check("bp.m_last", 64'(bus.m_last), 64'd0);
      check("bp.x0", 64'(bus.m_data), 64'(pk_x(2, 0)));
      check("bp.s_ready", 64'(bus.s_ready), 64'd0);
      check("bp.err", 64'(bus.err), (i == 0) ? 64'd1 : 64'd0);
      if (i < 4) @(negedge clk);
    end
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b0;
    @(negedge clk);
    check("bp.m_last_x1", 64'(bus.m_last), 64'd1);
    check("bp.x1", 64'(bus.m_data), 64'(pk_x(2, 1)));
    @(negedge clk);
    check("bp.no_dup", 64'(bus.m_valid), 64'd0);
    $display("backpressure: 5-cycle stall on x0=(2,0), then x1=(2,1)");

    // Continuous 8-pair stream: pair k y0=(10k+4,-6k), y1=(2,2k)
    // gives x0=(5k+3,-2k), x1=(5k+1,-4k).
    begin
      int x0_cyc[8];
      fork
        begin : driver
          for (int w = 0; w < 16; w++) begin
            int k;
            bit done;
            k = w / 2;
            bus.s_valid = 1'b1;
            bus.s_data  = (w % 2 == 0) ? pk_y(10*k + 4, -6*k) : pk_y(2, 2*k);
            done = 1'b0;
            for (int t = 0; t < 20 && !done; t++) begin
              if (bus.s_ready) done = 1'b1;
              @(negedge clk);
            end
            if (!done) check("stream.drive_timeout", 64'd0, 64'd1);
          end
          bus.s_valid = 1'b0;
        end
        begin : monitor
          int got;
          got = 0;
          for (int c = 0; c < 200 && got < 16; c++) begin
            @(negedge clk);
            if (bus.m_valid && bus.m_ready) begin
              int k;
              k = got / 2;
              if (got % 2 == 0) begin
                x0_cyc[k] = cycle;
                check("stream.x0", 64'(bus.m_data), 64'(pk_x(5*k + 3, -2*k)));
                check("stream.last0", 64'(bus.m_last), 64'd0);
              end else begin
                check("stream.x1", 64'(bus.m_data), 64'(pk_x(5*k + 1, -4*k)));
                check("stream.last1", 64'(bus.m_last), 64'd1);
              end
              $display("stream out %0d: pair %0d data=%08h last=%0d", got, k, bus.m_data, bus.m_last);
              got++;
            end
          end
          check("stream.count", 64'(got), 64'd16);
        end
      join
      for (int k = 1; k < 8; k++)
        check("stream.spacing", 64'(x0_cyc[k] - x0_cyc[k-1]), 64'd3);
    end

    // Reset after a lone y0: it must be discarded.
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = pk_y(100, 100);
    @(negedge clk);
    bus.s_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst.m_valid", 64'(bus.m_valid), 64'd0);
    check("rst.s_ready", 64'(bus.s_ready), 64'd1);
    @(negedge clk);
    check("rst.no_output", 64'(bus.m_valid), 64'd0);
    $display("reset: held y0 discarded");
    vecs[0].nm = "after_reset";
    run_pair(vecs[0]);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
